dma_timing_ctrl: RTL

Transfer sequencer for the DMA controller. It arbitrates four DREQ channels, runs the HRQ/HLDA bus handshake with the CPU, and steps the S0–S4 transfer state machine. It holds each channel's current address and word count and drives them to the datapath address buffers. It also generates the bus strobes (AEN, ADSTB, MEMR_N/MEMW_N, IOR_N/IOW_N), DACK and EOP_N for single-transfer mode.

---
 rtl/dma_timing_ctrl_if.sv | 53 +++++
 rtl/dma_timing_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dma_timing_ctrl_if.sv
// dma_timing_ctrl_if
//   Groups the DMA sequencer's request, handshake, load and bus-strobe
//   signals into one bundle. Clock and reset remain plain module ports.
//   master : the environment side (drives DREQ/HLDA/config, observes strobes)
//   slave  : the sequencer side (dma_timing_ctrl)
//   Signals:
//     DREQ      per-channel request, level sensitive
//     HLDA      CPU hold acknowledge
//     rot_pri   0 = fixed priority, 1 = rotating
//     xfer_type 2 bits per channel: 01 write, 10 read, 00/11 verify
//     ld_en/ld_ch/ld_addr/ld_count  channel address/count load
//     tc_clr    clears all terminal-count flags
//     HRQ, AEN, ADSTB, addr_out, DACK, MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N,
//     tc_stat, mask  sequencer outputs
interface dma_timing_ctrl_if #(
   parameter int NCH = 4,
   parameter int AW  = 16
);
   logic [NCH-1:0]   DREQ;
   logic             HLDA;
   logic             rot_pri;
   logic [2*NCH-1:0] xfer_type;
   logic             ld_en;
   logic [1:0]       ld_ch;
   logic [AW-1:0]    ld_addr;
   logic [AW-1:0]    ld_count;
   logic             tc_clr;

   logic             HRQ;
   logic             AEN;
   logic             ADSTB;
   logic [AW-1:0]    addr_out;
   logic [NCH-1:0]   DACK;
   logic             MEMR_N;
   logic             MEMW_N;
   logic             IOR_N;
   logic             IOW_N;
   logic             EOP_N;
   logic [NCH-1:0]   tc_stat;
   logic [NCH-1:0]   mask;

   modport master (
      output DREQ, HLDA, rot_pri, xfer_type, ld_en, ld_ch, ld_addr, ld_count, tc_clr,
      input  HRQ, AEN, ADSTB, addr_out, DACK, MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N,
             tc_stat, mask
   );

   modport slave (
      input  DREQ, HLDA, rot_pri, xfer_type, ld_en, ld_ch, ld_addr, ld_count, tc_clr,
      output HRQ, AEN, ADSTB, addr_out, DACK, MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N,
             tc_stat, mask
   );
endinterface

// File: rtl/dma_timing_ctrl.sv
// dma_timing_ctrl
//   Transfer sequencer for the DMA controller: arbitrates four DREQ channels
//   (fixed or rotating priority), runs the HRQ/HLDA hold handshake, steps the
//   SI/S0/S1..S4 transfer states, keeps per-channel address and word count,
//   and generates AEN, ADSTB, DACK, the memory/I/O strobes and EOP_N.
//   Ports:
//     CLK      system clock, rising edge
//     RESET_N  asynchronous active-low reset
//     bus      dma_timing_ctrl_if.slave (requests, handshake, load, strobes)
//   All outputs are registered: they are decoded from the next state and
//   captured on the same edge as the state register.
module dma_timing_ctrl #(
   parameter int NCH = 4,
   parameter int AW  = 16
) (
   input logic          CLK,
   input logic          RESET_N,
   dma_timing_ctrl_if.slave bus
);
   localparam int CW = $clog2(NCH);

   typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  act_ch, act_ch_nxt, last_ch, win_ch;
   logic           win_vld;
   logic [NCH-1:0] req;

   logic [AW-1:0]  cur_addr  [NCH];
   logic [AW-1:0]  cur_count [NCH];
   logic [NCH-1:0] mask_q, mask_d, tc_q, tc_d;

   logic           do_upd, cnt_zero, xfer_on, type_rd, type_wr;

   logic           hrq_q, aen_q, adstb_q, eop_n_q;
   logic           memr_n_q, memw_n_q, ior_n_q, iow_n_q;
   logic           hrq_d, aen_d, adstb_d, eop_n_d;
   logic           memr_n_d, memw_n_d, ior_n_d, iow_n_d;
   logic [NCH-1:0] dack_q, dack_d;
   logic [AW-1:0]  addr_q, addr_d;

   // Arbitration: scan from the highest-priority slot. In rotating mode the
   // scan starts at the channel after the last one served.
   always_comb begin
      int unsigned idx;
      req     = bus.DREQ & ~mask_q;
      win_vld = 1'b0;
      win_ch  = '0;
      idx     = 0;
      for (int unsigned k = 0; k < NCH; k++) begin
         idx = bus.rot_pri ? (32'(last_ch) + 1 + k) % NCH : k;
         if (!win_vld && req[CW'(idx)]) begin
            win_vld = 1'b1;
            win_ch  = CW'(idx);
         end
      end
   end

   // Next state
   always_comb begin
      state_nxt  = state;
      act_ch_nxt = act_ch;
      case (state)
         SI: if (|req) state_nxt = S0;
         S0: begin
            if (bus.HLDA) begin
               if (win_vld) begin
                  state_nxt  = S1;
                  act_ch_nxt = win_ch;
               end else begin
                  state_nxt = SI;
               end
            end
         end
         S1:      state_nxt = bus.HLDA ? S2 : SI;
         S2:      state_nxt = bus.HLDA ? S3 : SI;
         S3:      state_nxt = bus.HLDA ? S4 : SI;
         S4:      state_nxt = SI;
         default: state_nxt = SI;
      endcase
   end

   // Output decode from the next state, so the registered outputs line up
   // with the state they belong to.
   always_comb begin
      type_rd  = bus.xfer_type[{act_ch_nxt, 1'b1}] & ~bus.xfer_type[{act_ch_nxt, 1'b0}];
      type_wr  = ~bus.xfer_type[{act_ch_nxt, 1'b1}] & bus.xfer_type[{act_ch_nxt, 1'b0}];
      xfer_on  = state_nxt inside {S1, S2, S3, S4};
      cnt_zero = (cur_count[act_ch] == '0);

      hrq_d    = (state_nxt != SI);
      aen_d    = xfer_on;
      adstb_d  = (state_nxt == S1);
      dack_d   = '0;
      if (xfer_on) dack_d[act_ch_nxt] = 1'b1;
      addr_d   = addr_q;
      if (state_nxt == S1) addr_d = cur_addr[act_ch_nxt];
      memr_n_d = !((state_nxt inside {S2, S3}) && type_rd);
      ior_n_d  = !((state_nxt inside {S2, S3}) && type_wr);
      iow_n_d  = !((state_nxt == S3) && type_rd);
      memw_n_d = !((state_nxt == S3) && type_wr);
      eop_n_d  = !((state_nxt == S4) && cnt_zero);
   end

   // A load to the active channel in S4 replaces the update, so the update
   // and its terminal-count side effects are skipped in that case.
   always_comb begin
      do_upd = (state == S4) && !(bus.ld_en && (bus.ld_ch == act_ch));
      tc_d   = tc_q;
      mask_d = mask_q;
      if (bus.tc_clr) tc_d = '0;
      if (do_upd && cnt_zero) begin
         tc_d[act_ch]   = 1'b1;
         mask_d[act_ch] = 1'b1;
      end
      if (bus.ld_en) begin
         tc_d[bus.ld_ch]   = 1'b0;
         mask_d[bus.ld_ch] = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= SI;
         act_ch   <= '0;
         last_ch  <= '1;
         hrq_q    <= 1'b0;
         aen_q    <= 1'b0;
         adstb_q  <= 1'b0;
         dack_q   <= '0;
         addr_q   <= '0;
         memr_n_q <= 1'b1;
         memw_n_q <= 1'b1;
         ior_n_q  <= 1'b1;
         iow_n_q  <= 1'b1;
         eop_n_q  <= 1'b1;
         tc_q     <= '0;
         mask_q   <= '1;
      end else begin
         state    <= state_nxt;
         act_ch   <= act_ch_nxt;
         if (state == S4) last_ch <= act_ch;
         hrq_q    <= hrq_d;
         aen_q    <= aen_d;
         adstb_q  <= adstb_d;
         dack_q   <= dack_d;
         addr_q   <= addr_d;
         memr_n_q <= memr_n_d;
         memw_n_q <= memw_n_d;
         ior_n_q  <= ior_n_d;
         iow_n_q  <= iow_n_d;
         eop_n_q  <= eop_n_d;
         tc_q     <= tc_d;
         mask_q   <= mask_d;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            cur_addr[i]  <= '0;
            cur_count[i] <= '0;
         end
      end else begin
         if (do_upd) begin
            cur_addr[act_ch]  <= cur_addr[act_ch] + 1'b1;
            cur_count[act_ch] <= cur_count[act_ch] - 1'b1;
         end
         if (bus.ld_en) begin
            cur_addr[bus.ld_ch]  <= bus.ld_addr;
            cur_count[bus.ld_ch] <= bus.ld_count;
         end
      end
   end

   assign bus.HRQ      = hrq_q;
   assign bus.AEN      = aen_q;
   assign bus.ADSTB    = adstb_q;
   assign bus.addr_out = addr_q;
   assign bus.DACK     = dack_q;
   assign bus.MEMR_N   = memr_n_q;
   assign bus.MEMW_N   = memw_n_q;
   assign bus.IOR_N    = ior_n_q;
   assign bus.IOW_N    = iow_n_q;
   assign bus.EOP_N    = eop_n_q;
   assign bus.tc_stat  = tc_q;
   assign bus.mask     = mask_q;
endmodule
